// File: rtl/seg_to_hex_capture.sv
// Samples an active-low 7-segment bus, waits for it to settle, and decodes the
// settled pattern to a hex digit delivered through a one-entry valid/ready buffer.
module seg_to_hex_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_invalid,
  output logic [7:0] drop_cnt
);

  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic [6:0] seg_r;
  logic [6:0] last_pat;
  logic [3:0] cnt;
  logic [6:0] lit;
  logic       same;
  logic       settle;
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_invalid;

  assign lit    = ~seg_r;
  assign same   = (seg_i == seg_r);
  assign settle = same && (cnt == STABLE_M1) && (seg_r != last_pat);

  always_comb begin
    dec_digit   = 4'h0;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (lit)
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  // last_pat advances on every settle, delivered or dropped, so each distinct
  // settled pattern yields exactly one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r    <= 7'h7F;
      cnt      <= 4'd0;
      last_pat <= 7'h7F;
    end else begin
      seg_r <= seg_i;
      if (!same)
        cnt <= 4'd1;
      else if (cnt < STABLE)
        cnt <= cnt + 4'd1;
      if (settle)
        last_pat <= seg_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_digit   <= 4'h0;
      out_blank   <= 1'b0;
      out_invalid <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      case (state)
        EMPTY: begin
          if (settle) begin
            state       <= FULL;
            out_valid   <= 1'b1;
            out_digit   <= dec_digit;
            out_blank   <= dec_blank;
            out_invalid <= dec_invalid;
          end
        end
        FULL: begin
          if (settle) begin
            if (out_ready) begin
              out_digit   <= dec_digit;
              out_blank   <= dec_blank;
              out_invalid <= dec_invalid;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'h01;
            end
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Randomized and directed bench for seg_to_hex_capture, compared every cycle
// against a run-length / one-slot-mailbox model of the capture behaviour.
module tb_seg_to_hex_capture;

  localparam int S = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_i;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_invalid;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  seg_to_hex_capture #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_i      (seg_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digit  (out_digit),
    .out_blank  (out_blank),
    .out_invalid(out_invalid),
    .drop_cnt   (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: length of the current run of identical samples, last settled
  // pattern, and a one-slot mailbox with a saturating loss counter.
  logic [6:0] mPrev    = 7'h7F;
  int         mRun     = 0;
  logic [6:0] mLast    = 7'h7F;
  bit         mValid   = 0;
  int         mDigit   = 0;
  bit         mBlank   = 0;
  bit         mInvalid = 0;
  int         mDrop    = 0;

  function automatic logic [6:0] segOf(input logic [6:0] litPat);
    return ~litPat;
  endfunction

  task automatic modelDecode(input logic [6:0] seg, output int d, output bit b, output bit inv);
    logic [6:0] l;
    l   = ~seg;
    d   = 0;
    b   = (l == 7'h00);
    inv = !b;
    for (int i = 0; i < 16; i++)
      if (glyph[i] == l) begin
        d   = i;
        inv = 0;
      end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mPrev = 7'h7F; mRun = 0; mLast = 7'h7F;
        mValid = 0; mDigit = 0; mBlank = 0; mInvalid = 0; mDrop = 0;
      end else begin
        logic [6:0] s;
        bit ev;
        s = seg_i;
        mRun  = (s == mPrev) ? mRun + 1 : 1;
        mPrev = s;
        ev = (mRun == S) && (s != mLast);
        if (ev) begin
          mLast = s;
          if (!mValid || out_ready) begin
            modelDecode(s, mDigit, mBlank, mInvalid);
            mValid = 1;
          end else if (mDrop < 255) begin
            mDrop++;
          end
        end else if (mValid && out_ready) begin
          mValid = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("valid",   int'(out_valid),   int'(mValid));
        checkOutput("digit",   int'(out_digit),   mDigit);
        checkOutput("blank",   int'(out_blank),   int'(mBlank));
        checkOutput("invalid", int'(out_invalid), int'(mInvalid));
        checkOutput("drops",   int'(drop_cnt),    mDrop);
      end
    end
  end

  int evSeen, evDigit, evBlank, evInvalid;

  // Called at a negedge; drives inputs and holds them for the given cycles,
  // recording any valid output seen along the way.
  task automatic applyStimulus(input logic [6:0] pat, input logic rdy, input int hold);
    seg_i     = pat;
    out_ready = rdy;
    repeat (hold) begin
      @(negedge clk);
      if (out_valid) begin
        evSeen++;
        evDigit   = out_digit;
        evBlank   = out_blank;
        evInvalid = out_invalid;
      end
    end
  endtask

  task automatic waitValid(input int maxCycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    rst_n     = 1'b1;
    seg_i     = 7'h00;
    out_ready = 1'b0;
    #1 rst_n  = 1'b0;
    started   = 1;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_drops", int'(drop_cnt), 0);
    rst_n = 1'b1;
    applyStimulus(7'h7F, 1'b1, 20);
    checkOutput("idle_valid", int'(out_valid), 0);

    seg_i = segOf(7'h06);
    waitValid(10, lat);
    checkOutput("lat_1", lat, S);
    checkOutput("dec_1", int'(out_digit), 1);
    checkOutput("pin_model_1", mDigit, 1);
    @(negedge clk);
    checkOutput("one_cycle", int'(out_valid), 0);

    seg_i = segOf(7'h71);
    waitValid(10, lat);
    checkOutput("lat_F", lat, S);
    checkOutput("dec_F", int'(out_digit), 15);

    seg_i = 7'h7F;
    waitValid(10, lat);
    checkOutput("lat_blank", lat, S);
    checkOutput("blank_flag", int'(out_blank), 1);
    checkOutput("blank_digit", int'(out_digit), 0);

    evSeen = 0;
    applyStimulus(segOf(7'h5B), 1'b1, 3);
    applyStimulus(segOf(7'h4F), 1'b1, 8);
    checkOutput("glitch_events", evSeen, 1);
    checkOutput("glitch_digit", evDigit, 3);
    evSeen = 0;
    applyStimulus(segOf(7'h5B), 1'b1, 2);
    applyStimulus(segOf(7'h4F), 1'b1, 10);
    checkOutput("no_reemit", evSeen, 0);

    evSeen = 0;
    applyStimulus(7'h7E, 1'b1, 6);
    checkOutput("inv_events", evSeen, 1);
    checkOutput("inv_flag", evInvalid, 1);
    checkOutput("inv_digit", evDigit, 0);
    checkOutput("inv_blank", evBlank, 0);

    applyStimulus(segOf(7'h06), 1'b0, 6);
    applyStimulus(segOf(7'h5B), 1'b0, 6);
    applyStimulus(segOf(7'h4F), 1'b0, 6);
    checkOutput("bp_valid", int'(out_valid), 1);
    checkOutput("bp_digit", int'(out_digit), 1);
    checkOutput("bp_drops", int'(drop_cnt), 2);
    checkOutput("pin_model_drops", mDrop, 2);
    applyStimulus(segOf(7'h4F), 1'b1, 1);
    checkOutput("bp_release", int'(out_valid), 0);

    applyStimulus(segOf(7'h06), 1'b0, 6);
    applyStimulus(segOf(7'h66), 1'b0, S - 1);
    applyStimulus(segOf(7'h66), 1'b1, 1);
    out_ready = 1'b0;
    checkOutput("same_edge_valid", int'(out_valid), 1);
    checkOutput("same_edge_digit", int'(out_digit), 4);
    checkOutput("same_edge_drops", int'(drop_cnt), 2);

    for (int i = 0; i < 300; i++)
      applyStimulus((i % 2 == 0) ? segOf(7'h5B) : segOf(7'h06), 1'b0, S + 1);
    checkOutput("sat_drops", int'(drop_cnt), 255);
    checkOutput("sat_valid", int'(out_valid), 1);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", int'(out_valid), 0);
    checkOutput("async_reset_drops", int'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      int idx;
      int hold;
      logic [6:0] pat;
      idx  = int'($urandom_range(0, 19));
      hold = int'($urandom_range(1, 7));
      if (idx < 16)       pat = ~glyph[idx];
      else if (idx == 16) pat = 7'h7F;
      else if (idx == 17) pat = 7'h7E;
      else if (idx == 18) pat = 7'h3F;
      else                pat = 7'($urandom);
      for (int c = 0; c < hold; c++)
        applyStimulus(pat, 1'($urandom_range(0, 9) < 6), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
